// File: rtl/briey_program_loader.sv
// briey_program_loader
//
// Drives the Briey on-chip RAM reload port (program_load_*) for the host.
// A load command (base byte address, line count) is checked for legality.
// Each 512-bit host beat is then written as one 64 B line through an
// address/data handshake pair. After the last line the reload enable is
// dropped. core_run is raised after RELEASE_CYCLES idle cycles, and the load
// is then closed with a one-cycle done pulse. The block lives entirely in the
// axi4_mm_clk domain.
//
// Optional build macro: LOADER_CHECKSUM_EN adds a 32-bit XOR-fold checksum
// output covering every captured line of the current load.
//
// Ports:
//   axi4_mm_clk, axi4_mm_rst_n      clock, async active-low reset
//   cmd_start/base_addr/num_lines   load command (single-cycle strobe)
//   busy, done, err                 status (done = 1-cycle pulse, err sticky)
//   s_valid/s_ready/s_data          host line stream
//   program_load_en                 RAM reload enable
//   program_load_aw_*               line address channel
//   program_load_w_*                line data channel (strb always all-ones)
//   core_run                        core release
//   fsm_state                       debug view of the controller state
//   checksum                        (LOADER_CHECKSUM_EN only) XOR-fold of data
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clock edge where valid and ready are both high. Once valid is raised,
// it and its payload stay unchanged until that transfer. Valid never waits on
// ready.
module briey_program_loader #(
  parameter int ADDR_W         = 15,
  parameter int CNT_W          = 10,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic              axi4_mm_clk,
  input  logic              axi4_mm_rst_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [CNT_W-1:0]  cmd_num_lines,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [511:0]      s_data,
  output logic              program_load_en,
  output logic              program_load_aw_valid,
  input  logic              program_load_aw_ready,
  output logic [ADDR_W-1:0] program_load_aw_payload_addr,
  output logic              program_load_w_valid,
  input  logic              program_load_w_ready,
  output logic [511:0]      program_load_w_payload_data,
  output logic [63:0]       program_load_w_payload_strb,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              core_run,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_ISSUE   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // End-of-load address is computed wide enough that it can never wrap.
  localparam int              SUM_W     = ADDR_W + CNT_W + 1;
  localparam logic [SUM_W-1:0] ADDR_SPAN = SUM_W'(1) << ADDR_W;

  // RELEASE timeline, counted from the first RELEASE cycle:
  // core_run rises, then done pulses, then busy drops on the next cycle.
  localparam logic [4:0] REL_RUN  = 5'(RELEASE_CYCLES - 1);
  localparam logic [4:0] REL_DONE = 5'(RELEASE_CYCLES);
  localparam logic [4:0] REL_END  = 5'(RELEASE_CYCLES + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic             aw_done;
  logic             w_done;
  logic [4:0]       rel_cnt;

  logic [SUM_W-1:0] cmd_end;
  logic             cmd_illegal;
  logic             aw_hs;
  logic             w_hs;
  logic             aw_fin;
  logic             w_fin;

  assign cmd_end     = SUM_W'(cmd_base_addr) + (SUM_W'(cmd_num_lines) << 6);
  assign cmd_illegal = (cmd_num_lines == '0) || (cmd_base_addr[5:0] != 6'd0) ||
                       (cmd_end > ADDR_SPAN);

  assign aw_hs  = program_load_aw_valid && program_load_aw_ready;
  assign w_hs   = program_load_w_valid && program_load_w_ready;
  // A channel is finished if it completed earlier or completes this cycle.
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  assign s_ready                     = (state == ST_FETCH);
  assign program_load_w_payload_strb = '1;
  assign fsm_state                   = state;

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [31:0] fold_words(input logic [511:0] d);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc ^= d[i*32 +: 32];
    return acc;
  endfunction
`endif

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      state                        <= ST_IDLE;
      busy                         <= 1'b0;
      done                         <= 1'b0;
      err                          <= 1'b0;
      program_load_en              <= 1'b0;
      program_load_aw_valid        <= 1'b0;
      program_load_w_valid         <= 1'b0;
      program_load_aw_payload_addr <= '0;
      program_load_w_payload_data  <= '0;
      remaining                    <= '0;
      aw_done                      <= 1'b0;
      w_done                       <= 1'b0;
      rel_cnt                      <= '0;
      core_run                     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum                     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            if (cmd_illegal) begin
              err <= 1'b1;
            end else begin
              err                          <= 1'b0;
              program_load_aw_payload_addr <= cmd_base_addr;
              remaining                    <= cmd_num_lines;
              busy                         <= 1'b1;
              core_run                     <= 1'b0;
              program_load_en              <= 1'b1;
              state                        <= ST_FETCH;
`ifdef LOADER_CHECKSUM_EN
              checksum                     <= '0;
`endif
            end
          end
        end
        ST_FETCH: begin
          if (s_valid) begin
            program_load_w_payload_data <= s_data;
            program_load_aw_valid       <= 1'b1;
            program_load_w_valid        <= 1'b1;
            aw_done                     <= 1'b0;
            w_done                      <= 1'b0;
            state                       <= ST_ISSUE;
`ifdef LOADER_CHECKSUM_EN
            checksum                    <= checksum ^ fold_words(s_data);
`endif
          end
        end
        ST_ISSUE: begin
          if (aw_hs) begin
            program_load_aw_valid <= 1'b0;
            aw_done               <= 1'b1;
          end
          if (w_hs) begin
            program_load_w_valid <= 1'b0;
            w_done               <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            // Both valids are low from here on, so moving the address is safe.
            program_load_aw_payload_addr <= program_load_aw_payload_addr + ADDR_W'(64);
            remaining                    <= remaining - CNT_W'(1);
            aw_done                      <= 1'b0;
            w_done                       <= 1'b0;
            if (remaining == CNT_W'(1)) begin
              program_load_en <= 1'b0;
              rel_cnt         <= '0;
              state           <= ST_RELEASE;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_RELEASE: begin
          rel_cnt <= rel_cnt + 5'd1;
          if (rel_cnt == REL_RUN)  core_run <= 1'b1;
          if (rel_cnt == REL_DONE) done     <= 1'b1;
          if (rel_cnt == REL_END) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_briey_program_loader.sv
// Directed testbench for briey_program_loader. Each load is driven and
// observed cycle by cycle. Line addresses and data are scored against an
// expected queue, and cycle-exact timing is checked against hand-derived
// values.
module tb_briey_program_loader;

  localparam int ADDR_W = 15;
  localparam int CNT_W  = 10;
  localparam int RC     = 4;

  logic              clk;
  logic              rst_n;
  logic              cmd_start;
  logic [ADDR_W-1:0] cmd_base_addr;
  logic [CNT_W-1:0]  cmd_num_lines;
  logic              busy, done, err;
  logic              s_valid, s_ready;
  logic [511:0]      s_data;
  logic              en;
  logic              aw_valid, aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_valid, w_ready;
  logic [511:0]      w_data;
  logic [63:0]       w_strb;
  logic              core_run;
  logic [1:0]        fsm_state;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  briey_program_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .RELEASE_CYCLES(RC)) dut (
    .axi4_mm_clk                  (clk),
    .axi4_mm_rst_n                (rst_n),
    .cmd_start                    (cmd_start),
    .cmd_base_addr                (cmd_base_addr),
    .cmd_num_lines                (cmd_num_lines),
    .busy                         (busy),
    .done                         (done),
    .err                          (err),
    .s_valid                      (s_valid),
    .s_ready                      (s_ready),
    .s_data                       (s_data),
    .program_load_en              (en),
    .program_load_aw_valid        (aw_valid),
    .program_load_aw_ready        (aw_ready),
    .program_load_aw_payload_addr (aw_addr),
    .program_load_w_valid         (w_valid),
    .program_load_w_ready         (w_ready),
    .program_load_w_payload_data  (w_data),
    .program_load_w_payload_strb  (w_strb),
`ifdef LOADER_CHECKSUM_EN
    .checksum                     (checksum),
`endif
    .core_run                     (core_run),
    .fsm_state                    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [511:0]      exp_data_q[$];

  int                r_busy, r_done, r_en_fall, r_run_rise, r_first_valid;
  int                r_proto, r_split_aw, r_split_w, r_err_seen;
  logic [ADDR_W-1:0] r_last_addr;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] line_data(input int mode, input int k);
    logic [511:0] d;
    d = '0;
    case (mode)
      1: for (int j = 0; j < 16; j++) d[j*32 +: 32] = 32'h0000_0001;
      2: d[31:0] = 32'hDEAD_BEEF;
      default:
        for (int j = 0; j < 16; j++)
          d[j*32 +: 32] = (32'(k) * 32'h0100_0193) ^ (32'(j) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endcase
    return d;
  endfunction

  // Pulse a command; returns at the sample point just after the accepting edge.
  task automatic start_cmd(input logic [ADDR_W-1:0] base, input int n);
    cmd_base_addr = base;
    cmd_num_lines = CNT_W'(n);
    cmd_start     = 1'b1;
    tick();
    cmd_start     = 1'b0;
  endtask

  // Runs one legal load. aw_dly/w_dly: cycles each valid waits before ready.
  // gap: s_valid high one cycle in gap. poke: cycle index at which an illegal
  // cmd_start is injected while busy (-1 for none).
  task automatic run_load(input logic [ADDR_W-1:0] base, input int n, input int mode,
                          input int aw_dly, input int w_dly, input int gap,
                          input int poke, input int budget);
    int                k;
    int                sent;
    int                aw_cnt;
    int                w_cnt;
    logic              p_aw_v, p_aw_hs, p_w_v, p_w_hs;
    logic [ADDR_W-1:0] p_addr;
    logic [511:0]      p_data;
    r_busy = 0; r_done = 0; r_en_fall = -1; r_run_rise = -1; r_first_valid = -1;
    r_proto = 0; r_split_aw = 0; r_split_w = 0; r_err_seen = 0; r_last_addr = '0;
    exp_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(base + ADDR_W'(64 * i));
      exp_data_q.push_back(line_data(mode, i));
    end
    sent = 0; aw_cnt = 0; w_cnt = 0;
    p_aw_v = 0; p_aw_hs = 0; p_w_v = 0; p_w_hs = 0; p_addr = '0; p_data = '0;
    start_cmd(base, n);
    for (k = 0; k < budget; k++) begin
      if (busy) r_busy++;
      if (done) r_done++;
      if (err) r_err_seen++;
      if (!en && r_en_fall < 0) r_en_fall = k;
      if (core_run && r_run_rise < 0) r_run_rise = k;
      if ((aw_valid || w_valid) && r_first_valid < 0) r_first_valid = k;
      if (p_aw_v && !p_aw_hs && (!aw_valid || aw_addr !== p_addr)) r_proto++;
      if (p_w_v && !p_w_hs && (!w_valid || w_data !== p_data)) r_proto++;
      if ((p_aw_hs && aw_valid) || (p_w_hs && w_valid)) r_proto++;
      if (s_ready && (aw_valid || w_valid)) r_proto++;
      if (aw_valid && !w_valid) r_split_aw++;
      if (w_valid && !aw_valid) r_split_w++;
      if (!busy) break;
      // drive inputs for the coming edge
      cmd_start = (k == poke);
      if (k == poke) begin
        cmd_base_addr = ADDR_W'(16);
        cmd_num_lines = '0;
      end
      aw_ready = (aw_cnt >= aw_dly);
      w_ready  = (w_cnt >= w_dly);
      s_valid  = (gap <= 1) || ((k % gap) == 0);
      s_data   = line_data(mode, sent);
      if (s_valid && s_ready) sent++;
      if (aw_valid && aw_ready) begin
        if (exp_q.size() == 0) r_proto++;
        else chk("aw_addr", aw_addr, exp_q.pop_front());
        r_last_addr = aw_addr;
      end
      if (w_valid && w_ready) begin
        if (exp_data_q.size() == 0) r_proto++;
        else chk("w_data", w_data, exp_data_q.pop_front());
      end
      p_aw_v = aw_valid; p_aw_hs = aw_valid && aw_ready; p_addr = aw_addr;
      p_w_v  = w_valid;  p_w_hs  = w_valid && w_ready;   p_data = w_data;
      aw_cnt = aw_valid ? aw_cnt + 1 : 0;
      w_cnt  = w_valid ? w_cnt + 1 : 0;
      tick();
    end
    cmd_start = 1'b0;
    s_valid   = 1'b0;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    chk("load_finished_in_budget", busy, 1'b0);
    chk("aw_lines_left", exp_q.size(), 0);
    chk("w_lines_left", exp_data_q.size(), 0);
    chk("handshake_rules", r_proto, 0);
    chk("done_count", r_done, 1);
  endtask

  task automatic illegal_cmd(input string tag, input logic [ADDR_W-1:0] base, input int n);
    start_cmd(base, n);
    chk({tag, "_err"}, err, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_en"}, en, 1'b0);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    tick();
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_busy_late"}, busy, 1'b0);
    chk({tag, "_err_sticky"}, err, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; cmd_start = 1'b0; cmd_base_addr = '0; cmd_num_lines = '0;
    s_valid = 1'b0; s_data = '0; aw_ready = 1'b0; w_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_en", en, 1'b0);
    chk("rst_aw_valid", aw_valid, 1'b0);
    chk("rst_w_valid", w_valid, 1'b0);
    chk("rst_core_run", core_run, 1'b0);
    chk("rst_aw_addr", aw_addr, 0);
    chk("rst_w_data", w_data, 0);
    chk("strb_all_ones", w_strb, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_state", fsm_state, 2'd0);

    // 4 lines from 0, everything ready
    run_load(15'h0000, 4, 0, 0, 0, 1, -1, 200);
    chk("t1_busy_cycles", r_busy, 8 + RC + 2);
    chk("t1_first_valid", r_first_valid, 1);
    chk("t1_en_fall", r_en_fall, 8);
    chk("t1_release_gap", r_run_rise - r_en_fall, RC);
    chk("t1_last_addr", r_last_addr, 15'h00C0);
    chk("t1_core_run", core_run, 1'b1);

    // aw_ready held off 3 cycles; illegal cmd_start injected while busy
    run_load(15'h0100, 2, 0, 3, 0, 1, 2, 200);
    chk("t2_aw_only_cycles", r_split_aw, 6);
    chk("t2_w_only_cycles", r_split_w, 0);
    chk("t2_busy_cycles", r_busy, 16);
    chk("t2_err_ignored", r_err_seen, 0);
    chk("t2_last_addr", r_last_addr, 15'h0140);

    // swapped: w_ready held off 3 cycles
    run_load(15'h0200, 2, 0, 0, 3, 1, -1, 200);
    chk("t3_w_only_cycles", r_split_w, 6);
    chk("t3_aw_only_cycles", r_split_aw, 0);
    chk("t3_busy_cycles", r_busy, 16);

    // illegal commands
    illegal_cmd("zero_lines", 15'h0000, 0);
    illegal_cmd("misaligned", 15'h0010, 1);
    illegal_cmd("overflow", 15'h7FC0, 2);
    chk("illegal_keeps_core_run", core_run, 1'b1);

    // exact top-of-RAM line is legal and clears err
    run_load(15'h7FC0, 1, 0, 0, 0, 1, -1, 200);
    chk("edge_err_cleared", err, 1'b0);
    chk("edge_err_seen", r_err_seen, 0);
    chk("edge_busy_cycles", r_busy, 2 + RC + 2);
    chk("edge_core_run_rise", r_run_rise, 6);
    chk("edge_last_addr", r_last_addr, 15'h7FC0);

    // full 32 KB with gapped host data
    run_load(15'h0000, 512, 0, 0, 0, 3, -1, 5000);
    chk("full_last_addr", r_last_addr, 15'h7FC0);
    chk("full_err", r_err_seen, 0);

    // reset during line 2
    s_valid = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
    start_cmd(15'h0000, 4);
    tick(); tick(); tick();
    chk("mid_aw_valid", aw_valid, 1'b1);
    chk("mid_aw_addr", aw_addr, 15'h0040);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_aw_valid", aw_valid, 1'b0);
    chk("arst_w_valid", w_valid, 1'b0);
    chk("arst_en", en, 1'b0);
    chk("arst_core_run", core_run, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_s_ready", s_ready, 1'b0);
    s_valid = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    run_load(15'h0400, 2, 0, 1, 1, 1, -1, 200);
    chk("post_rst_busy_cycles", r_busy, 6 + RC + 2);
    chk("post_rst_last_addr", r_last_addr, 15'h0440);

`ifdef LOADER_CHECKSUM_EN
    run_load(15'h0000, 2, 1, 0, 0, 1, -1, 200);
    chk("checksum_ones", checksum, 32'h0000_0000);
    run_load(15'h0040, 1, 2, 0, 0, 1, -1, 200);
    chk("checksum_deadbeef", checksum, 32'hDEAD_BEEF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
